// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS debug-side memory dump path.
// FSM state encoding, skid FIFO depth and default widths.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } dump_state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry synchronous FIFO buffering memory read returns.
// Async active-high reset; entries clear so the head reads 0 after reset.
module dump_skid_fifo
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              wr_q;
  logic              rd_q;
  logic [1:0]        cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/mem_dump_reader.sv
// Streams a window of memory words out over valid/ready after a start pulse.
// Define DUMP_CHECKSUM_EN to append a modulo-2^DATA_W sum beat to each dump.
module mem_dump_reader
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remain_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  beat_q;
  logic              inflight_q;
  logic              busy_q;
  logic              zdone_q;

  logic              f_empty;
  logic [1:0]        f_count;
  logic [DATA_W-1:0] f_head;
  logic              pop;
  logic              issue;
  logic              mem_last;
  logic              fin;
  logic [2:0]        credit;

  dump_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset_b),
    .push     (inflight_q),
    .push_data(rd_data),
    .pop      (pop),
    .head     (f_head),
    .empty    (f_empty),
    .count    (f_count)
  );

  // Count a same-cycle pop as freed space so a steady stream runs at full rate.
  assign credit = {1'b0, f_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue  = (state_q == READ) && (remain_q != '0) && (credit < DEPTH);
  assign mem_last = !f_empty && (beat_q == count_q - CNT_W'(1));

  assign rd_en   = issue;
  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = zdone_q | fin;

`ifdef DUMP_CHECKSUM_EN
  logic              csum_q;
  logic [DATA_W-1:0] sum_q;

  assign out_valid = csum_q | !f_empty;
  assign out_data  = csum_q ? sum_q : f_head;
  assign out_last  = csum_q;
  assign pop       = !f_empty && !csum_q && out_ready;
  assign fin       = (state_q == DRAIN) && csum_q && out_ready;
`else
  assign out_valid = !f_empty;
  assign out_data  = f_head;
  assign out_last  = mem_last;
  assign pop       = !f_empty && out_ready;
  assign fin       = (state_q == DRAIN) && pop && mem_last;
`endif

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      zdone_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= 1'b0;
      sum_q      <= '0;
`endif
    end else begin
      zdone_q    <= 1'b0;
      inflight_q <= issue;
      if (pop) begin
        beat_q <= beat_q + CNT_W'(1);
      end
      if (issue) begin
        addr_q   <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - CNT_W'(1);
      end
`ifdef DUMP_CHECKSUM_EN
      if (pop) begin
        sum_q <= sum_q + f_head;
      end
      if (pop && mem_last) begin
        csum_q <= 1'b1;
      end
`endif
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            addr_q   <= start_addr;
            remain_q <= word_count;
            count_q  <= word_count;
            beat_q   <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum_q    <= '0;
            csum_q   <= (word_count == '0);
            busy_q   <= 1'b1;
            state_q  <= (word_count == '0) ? DRAIN : READ;
`else
            if (word_count == '0) begin
              state_q <= DONE;
              zdone_q <= 1'b1;
            end else begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end
`endif
          end
        end
        READ: begin
          if (issue && remain_q == CNT_W'(1)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fin) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule
